// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC infrared frame encoder producing a pulse-distance envelope
// and an optionally carrier-modulated LED drive.
module nec_ir_tx #(
   parameter int UNIT_CYCLES  = 28125,
   parameter int CARRIER_HALF = 658,
   parameter int GAP_UNITS    = 16,
   parameter bit CARRIER_EN   = 1'b1
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   input  logic       tx_repeat,
   output logic       ir_envelope,
   output logic       ir_tx,
   output logic       busy,
   output logic       frame_done
);
   localparam int CW = $clog2(UNIT_CYCLES);
   localparam int HW = $clog2(CARRIER_HALF + 1);

   typedef enum logic [2:0] {
      IDLE,
      LEADER_MARK,
      LEADER_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      GAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cyc_q;
   logic [15:0]   units_q, units_d;
   logic [HW-1:0] car_cnt_q;
   logic [31:0]   shift_q;
   logic [4:0]    idx_q;
   logic          rpt_q, car_q, env_q, ready_q, busy_q, done_q;
   logic          mark_d, advance;

   // units_q holds remaining whole units minus one; a state ends when both counters hit zero
   assign advance = state_q == IDLE ? tx_valid && ready_q : cyc_q == '0 && units_q == '0;

   always_comb begin
      state_d = IDLE;
      units_d = '0;
      case (state_q)
         IDLE: begin
            state_d = LEADER_MARK;
            units_d = 16'd15;
         end
         LEADER_MARK: begin
            state_d = LEADER_SPACE;
            units_d = rpt_q ? 16'd3 : 16'd7;
         end
         LEADER_SPACE: state_d = rpt_q ? STOP_MARK : BIT_MARK;
         BIT_MARK: begin
            state_d = BIT_SPACE;
            units_d = shift_q[0] ? 16'd2 : 16'd0;
         end
         BIT_SPACE: state_d = idx_q == 5'd31 ? STOP_MARK : BIT_MARK;
         STOP_MARK: begin
            state_d = GAP;
            units_d = 16'(GAP_UNITS - 1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign mark_d = state_d inside {LEADER_MARK, BIT_MARK, STOP_MARK};

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q   <= IDLE;
         cyc_q     <= '0;
         units_q   <= '0;
         car_cnt_q <= '0;
         shift_q   <= '0;
         idx_q     <= '0;
         rpt_q     <= 1'b0;
         car_q     <= 1'b0;
         env_q     <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (advance) begin
            state_q   <= state_d;
            units_q   <= units_d;
            cyc_q     <= CW'(UNIT_CYCLES - 1);
            car_cnt_q <= HW'(CARRIER_HALF - 1);
            car_q     <= mark_d;
            env_q     <= mark_d;
            ready_q   <= state_d == IDLE;
            busy_q    <= state_d != IDLE;
            done_q    <= state_d == GAP;
            if (state_q == IDLE) begin
               shift_q <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
               rpt_q   <= tx_repeat;
               idx_q   <= '0;
            end
            if (state_q == BIT_SPACE) begin
               shift_q <= shift_q >> 1;
               idx_q   <= idx_q + 5'd1;
            end
         end else if (state_q != IDLE) begin
            cyc_q     <= cyc_q == '0 ? CW'(UNIT_CYCLES - 1) : cyc_q - 1'b1;
            units_q   <= cyc_q == '0 ? units_q - 16'd1 : units_q;
            car_cnt_q <= car_cnt_q == '0 ? HW'(CARRIER_HALF - 1) : car_cnt_q - 1'b1;
            car_q     <= car_cnt_q == '0 ? env_q & ~car_q : car_q;
         end
      end
   end

   assign tx_ready    = ready_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign ir_envelope = env_q;
   assign ir_tx       = CARRIER_EN ? car_q : env_q;
endmodule

// File: tb/tb_nec_ir_tx.sv
// tb_nec_ir_tx: directed frames on a carrier and a non-carrier instance; a
// monitor decodes envelope run lengths and checks them against a scoreboard.
module tb_nec_ir_tx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx_valid = 1'b0;
   logic [7:0] tx_addr = '0;
   logic [7:0] tx_cmd = '0;
   logic tx_repeat = 1'b0;
   logic rdy_a, busy_a, env_a, irtx_a, done_a;
   logic rdy_b, busy_b, env_b, irtx_b, done_b;
   logic [4:0] vec_a, vec_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0, hs_cyc = 0, hs_cnt = 0, done_cyc = 0, done_cnt = 0;
   int ready_cyc = 0, ready_cnt = 0;
   int run_len = 0, hi_cnt = 0, car_bad = 0, b_bad = 0, ctl_bad = 0;
   logic prev_env = 1'b0, prev_done = 1'b0, prev_rdy = 1'b1;
   int runs[$];
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   nec_ir_tx #(.UNIT_CYCLES(4), .CARRIER_HALF(1), .GAP_UNITS(2), .CARRIER_EN(1'b1)) dut_a (
      .clk_50(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(rdy_a),
      .tx_addr(tx_addr), .tx_cmd(tx_cmd), .tx_repeat(tx_repeat),
      .ir_envelope(env_a), .ir_tx(irtx_a), .busy(busy_a), .frame_done(done_a));

   nec_ir_tx #(.UNIT_CYCLES(4), .CARRIER_HALF(1), .GAP_UNITS(2), .CARRIER_EN(1'b0)) dut_b (
      .clk_50(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(rdy_b),
      .tx_addr(tx_addr), .tx_cmd(tx_cmd), .tx_repeat(tx_repeat),
      .ir_envelope(env_b), .ir_tx(irtx_b), .busy(busy_b), .frame_done(done_b));

   assign vec_a = {rdy_a, busy_a, env_a, irtx_a, done_a};
   assign vec_b = {rdy_b, busy_b, env_b, irtx_b, done_b};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // {width_error, repeat, 32-bit word LSB-first} from the recorded mark/space runs
   function automatic logic [33:0] decode();
      logic bad = 1'b0;
      logic r;
      logic [31:0] w = '0;
      r = runs.size() == 3;
      if (runs.size() < 3 || runs[0] != 64) bad = 1'b1;
      if (r) begin
         if (runs[1] != 16 || runs[2] != 4) bad = 1'b1;
      end else if (runs.size() != 67) bad = 1'b1;
      else begin
         if (runs[1] != 32 || runs[66] != 4) bad = 1'b1;
         for (int i = 0; i < 32; i++) begin
            if (runs[2+2*i] != 4) bad = 1'b1;
            if (runs[3+2*i] != 4 && runs[3+2*i] != 12) bad = 1'b1;
            w[i] = runs[3+2*i] == 12;
         end
      end
      return {bad, r, w};
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!reset && tx_valid && rdy_a) begin
         hs_cyc = cyc;
         hs_cnt++;
      end
   end

   always @(negedge clk) begin
      logic [33:0] dec;
      logic [32:0] expv;
      if (reset) begin
         runs.delete();
         prev_env = 1'b0;
         run_len = 0;
         hi_cnt = 0;
         car_bad = 0;
         b_bad = 0;
         prev_done = 1'b0;
         prev_rdy = 1'b1;
      end else begin
         if (env_a !== prev_env) begin
            if (prev_env || runs.size() > 0) runs.push_back(run_len);
            run_len = 1;
            prev_env = env_a;
         end else run_len++;
         if (env_a) hi_cnt++;
         if (irtx_a !== (env_a && run_len[0])) car_bad++;
         if (irtx_b !== env_a || env_b !== env_a) b_bad++;
         if (busy_a === rdy_a || (done_a && prev_done) || (env_a && !busy_a)) ctl_bad++;
         if (rdy_a && !prev_rdy) begin
            ready_cyc = cyc;
            ready_cnt++;
         end
         prev_rdy = rdy_a;
         prev_done = done_a;
         if (done_a) begin
            done_cyc = cyc;
            dec = decode();
            expv = sb.size() > 0 ? sb.pop_front() : '1;
            check("frame_bits", 64'(dec[32:0]), 64'(expv));
            check("frame_widths", 64'(dec[33]), 64'd0);
            check("frame_len", 64'(done_cyc - hs_cyc), expv[32] ? 64'd84 : 64'd484);
            check("env_high", 64'(hi_cnt), expv[32] ? 64'd68 : 64'd196);
            check("carrier", 64'(car_bad), 64'd0);
            check("no_carrier", 64'(b_bad), 64'd0);
            runs.delete();
            hi_cnt = 0;
            car_bad = 0;
            b_bad = 0;
            done_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_hs(input int n, input string tag);
      for (int i = 0; i < 3000 && hs_cnt == n; i++) tick();
      check(tag, 64'(hs_cnt - n), 64'd1);
   endtask

   task automatic wait_done(input int n, input string tag);
      for (int i = 0; i < 3000 && done_cnt == n; i++) tick();
      check(tag, 64'(done_cnt - n), 64'd1);
   endtask

   task automatic wait_ready(input int n, input string tag);
      for (int i = 0; i < 3000 && ready_cnt == n; i++) tick();
      check(tag, 64'(ready_cnt - n), 64'd1);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] c, input logic r);
      tx_addr = a;
      tx_cmd = c;
      tx_repeat = r;
      tx_valid = 1'b1;
      sb.push_back({r, r ? 32'h0 : {~c, c, ~a, a}});
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] c, input logic r);
      int h, d, rc;
      h = hs_cnt;
      d = done_cnt;
      rc = ready_cnt;
      send(a, c, r);
      wait_hs(h, "hs");
      tx_valid = 1'b0;
      check("busy_after_hs", 64'(vec_a[4:2]), 64'b011);
      tx_addr = ~a;
      tx_repeat = ~r;
      wait_done(d, "done_timeout");
      wait_ready(rc, "ready_timeout");
      check("ready_after_done", 64'(ready_cyc - done_cyc), 64'd8);
   endtask

   initial begin
      int h, d;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("reset_state_a", 64'(vec_a), 64'b10000);
      check("reset_state_b", 64'(vec_b), 64'b10000);
      repeat (20) tick();
      check("idle_a", 64'(vec_a), 64'b10000);
      check("idle_b", 64'(vec_b), 64'b10000);

      frame(8'h00, 8'h45, 1'b0);
      frame(8'h12, 8'h34, 1'b1);

      h = hs_cnt;
      d = done_cnt;
      send(8'hA5, 8'h3C, 1'b0);
      wait_hs(h, "hs_first");
      send(8'h5A, 8'hC3, 1'b0);
      wait_hs(h + 1, "hs_b2b");
      check("b2b_spacing", 64'(hs_cyc - done_cyc), 64'd9);
      tx_valid = 1'b0;
      wait_done(d + 1, "done_b2b");

      h = hs_cnt;
      d = done_cnt;
      send(8'hC3, 8'h81, 1'b0);
      wait_hs(h, "hs_abort");
      tx_valid = 1'b0;
      for (int i = 0; i < 2000 && runs.size() != 23; i++) tick();
      check("reach_bit10", 64'(runs.size()), 64'd23);
      reset = 1'b1;
      tick();
      check("abort_a", 64'(vec_a), 64'b10000);
      check("abort_b", 64'(vec_b), 64'b10000);
      reset = 1'b0;
      check("sb_abort", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      repeat (600) tick();
      check("no_done_after_abort", 64'(done_cnt), 64'(d));

      frame(8'hFF, 8'h00, 1'b0);
      check("frames_total", 64'(done_cnt), 64'd5);
      check("control_rules", 64'(ctl_bad), 64'd0);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
- NEC-protocol infrared transmitter; the encoder counterpart of the board's IR receive/decode path.
- Takes an 8-bit address/command pair, or a repeat request, over a valid/ready handshake.
- Emits the NEC frame as a pulse-distance envelope and as a carrier-modulated LED drive on a GPIO pin.
- Used for loop-back testing of the IR receiver and for commanding a second board.

Parameters:
- UNIT_CYCLES, 28125, clk_50 cycles per NEC time unit (562.5 us at 50 MHz); must be >= 2.
- CARRIER_HALF, 658, clk_50 cycles per carrier half-period (~38 kHz); must be >= 1.
- GAP_UNITS, 16, minimum idle units forced after every frame before tx_ready reasserts; must be >= 1.
- CARRIER_EN, 1, 1 = ir_tx is modulated; 0 = ir_tx equals ir_envelope.

Ports:
- clk_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  request to send; qualified by tx_ready.
- tx_ready  out  1  high only in IDLE; a transfer occurs when tx_valid & tx_ready.
- tx_addr  in  8  NEC address, sampled on transfer.
- tx_cmd  in  8  NEC command, sampled on transfer.
- tx_repeat  in  1  sampled on transfer; 1 = send a repeat code (tx_addr/tx_cmd ignored).
- ir_envelope  out  1  unmodulated mark (1) / space (0) waveform.
- ir_tx  out  1  LED drive: ir_envelope gated by carrier.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  single-cycle pulse on the first cycle after the stop mark ends.

Behaviour:
- Reset: all outputs 0 except tx_ready=1; state IDLE; unit counter, carrier counter and bit index cleared.
- Reset asserted mid-frame aborts the frame. Outputs reach reset values on the next edge; no frame_done is generated.
- Transfer:
  - On the cycle with tx_valid & tx_ready, latch shift register = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr} (32 bits, bit 0 sent first) and latch the repeat flag.
  - The next cycle is the first LEADER_MARK cycle: ir_envelope=1, busy=1, tx_ready=0.
- Timing: every state lasts an exact multiple of UNIT_CYCLES. The counter reloads at each state entry, so there is no cumulative drift.
- States and durations, in units:
  - IDLE: ready; waits for a transfer.
  - LEADER_MARK: 16, mark.
  - LEADER_SPACE: 8, space, or 4 if repeat. Exits to BIT_MARK (bit index 0), or to STOP_MARK if repeat.
  - BIT_MARK: 1, mark.
  - BIT_SPACE: 1 if the current bit is 0, 3 if it is 1. Then shift right and increment index. After index 31 go to STOP_MARK, else BIT_MARK.
  - STOP_MARK: 1, mark. Exits to GAP, pulsing frame_done on GAP's first cycle.
  - GAP: GAP_UNITS, space; busy=1, tx_ready=0. Exits to IDLE.
- tx_valid held high through GAP is accepted on the first IDLE cycle. Back-to-back frames are therefore separated by GAP_UNITS*UNIT_CYCLES + 1 space cycles.
- Carrier:
  - The counter restarts at every mark entry, so each mark begins with ir_tx=1.
  - ir_tx toggles every CARRIER_HALF cycles while ir_envelope=1, and is 0 during spaces.
  - A mark may end mid-period; the carrier is forced low with the envelope.
- Inputs tx_addr/tx_cmd/tx_repeat changing while busy have no effect on the frame in flight.
- Frame durations:
  - Full frame, leader through stop mark: 16+8+64+(2 x number of one-bits)+1 units, always 121 units, since the complemented bytes give 16 ones.
  - Repeat frame: 21 units.

Test Plan:
- Reset, then idle with tx_valid=0 -> tx_ready=1, busy=0, ir_envelope=0, ir_tx=0, frame_done=0 indefinitely.
- UNIT_CYCLES=4, CARRIER_EN=0, GAP_UNITS=2; send addr 0x00, cmd 0x45 -> envelope rises 1 cycle after the handshake and is high 64 cycles, low 32. Decoded space widths give bits 0x00,0xFF,0x45,0xBA LSB-first. Total active frame is 484 cycles, with 196 envelope-high cycles. frame_done pulses at cycle 485 after the handshake; tx_ready returns 8 cycles later.
- Same setup with tx_repeat=1 -> envelope 64 high, 16 low, 4 high, then GAP; frame_done pulses once; the shift register is unused.
- CARRIER_EN=1, CARRIER_HALF=1, UNIT_CYCLES=4 -> during each mark ir_tx follows 1,0,1,0...; each bit mark yields ir_tx=1010; ir_tx=0 in every space.
- tx_valid held high with two payloads queued -> second handshake occurs exactly on the first IDLE cycle. tx_addr toggled mid-frame leaves the first frame's bits unchanged.
- reset pulsed during BIT_SPACE of bit 10 -> next cycle ir_envelope=0, busy=0, tx_ready=1, no frame_done. A following frame is transmitted correctly from its leader.
